// File: rtl/agc_run_ctrl_pkg.sv
// Shared types and helpers for the AGC run controller: FSM state encoding
// and a saturating increment used by the cycle and stall counters.
package agc_run_pkg;

  typedef enum logic [2:0] {
    RS_IDLE    = 3'd0,
    RS_HOLD    = 3'd1,
    RS_RUN     = 3'd2,
    RS_DONE    = 3'd3,
    RS_TIMEOUT = 3'd4
  } run_state_t;

  localparam int SAT_W = 64;

  // Callers zero-extend narrower counters and pass their own all-ones ceiling.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_value);
    logic [SAT_W-1:0] result;
    if (value >= max_value) begin
      result = max_value;
    end else begin
      result = value + 64'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/agc_run_ctrl_halt_filter.sv
// Per-core halt glitch filter: halt_in must stay high for HALT_FILTER enabled
// cycles before the sticky halted flag sets; only clear drops the flag.
module agc_halt_filter #(
  parameter int HALT_FILTER = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic halt_in,
  output logic halted_out,
  output logic halted_next
);

  localparam int FW = $clog2(HALT_FILTER + 1);
  localparam logic [FW-1:0] F_MAX = FW'(HALT_FILTER);

  logic [FW-1:0] cnt_r;
  logic [FW-1:0] cnt_s;
  logic          halted_r;
  logic          halted_s;

  // Next filter count and flag; the count parks at F_MAX while halt holds.
  always_comb begin
    cnt_s    = cnt_r;
    halted_s = halted_r;
    if (clear) begin
      cnt_s    = '0;
      halted_s = 1'b0;
    end else if (enable) begin
      if (!halt_in) begin
        cnt_s = '0;
      end else if (cnt_r != F_MAX) begin
        cnt_s = cnt_r + FW'(1'b1);
      end else begin
        cnt_s = cnt_r;
      end
      if (cnt_s == F_MAX) begin
        halted_s = 1'b1;
      end else begin
        halted_s = halted_r;
      end
    end else begin
      cnt_s    = cnt_r;
      halted_s = halted_r;
    end
  end

  // Filter state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= '0;
      halted_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_s;
      halted_r <= halted_s;
    end
  end

  assign halted_out  = halted_r;
  assign halted_next = halted_s;

endmodule

// File: rtl/agc_run_ctrl.sv
// AGC run controller: holds the cores in reset, runs them until every core
// has a filtered halt or the watchdog expires, and accounts cycles and stalls.
module agc_run_ctrl
  import agc_run_pkg::*;
#(
  parameter int NUM_CORES      = 1,
  parameter int RESET_HOLD     = 4,
  parameter int HALT_FILTER    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] halt,
  input  logic [NUM_CORES-1:0] stall,
  output logic                 core_reset_n,
  output logic                 running,
  output logic                 done,
  output logic                 timed_out,
  output logic [NUM_CORES-1:0] halted_mask,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     stall_count
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  TO_VAL    = CNT_W'(TIMEOUT_CYCLES);
  localparam bit                WDOG_EN   = (TIMEOUT_CYCLES != 32'sd0);
  localparam longint TO_LIMIT = (CNT_W >= 63) ? 64'sh7FFF_FFFF_FFFF_FFFF
                                              : ((64'sd1 <<< CNT_W) - 64'sd1);

  if (NUM_CORES < 1 || RESET_HOLD < 1 || HALT_FILTER < 1 || CNT_W < 1 || CNT_W > SAT_W ||
      TIMEOUT_CYCLES < 0 || longint'(TIMEOUT_CYCLES) > TO_LIMIT) begin : g_param_check
    $error("agc_run_ctrl: illegal parameter combination");
  end

  run_state_t             state_r;
  run_state_t             state_s;
  logic [HOLD_W-1:0]      hold_cnt_r;
  logic [CNT_W-1:0]       cycle_r;
  logic [CNT_W-1:0]       stall_r;
  logic [CNT_W-1:0]       cycle_inc_s;
  logic [CNT_W-1:0]       stall_inc_s;
  logic [NUM_CORES-1:0]   halted_next_s;
  logic                   start_ok_s;
  logic                   run_act_s;
  logic                   hold_act_s;
  logic                   timeout_hit_s;

  assign start_ok_s  = start && !abort &&
                       (state_r == RS_IDLE || state_r == RS_DONE || state_r == RS_TIMEOUT);
  assign run_act_s   = (state_r == RS_RUN) && !abort;
  assign hold_act_s  = (state_r == RS_HOLD) && !abort;
  assign cycle_inc_s = CNT_W'(sat_inc(SAT_W'(cycle_r), SAT_W'(CNT_MAX)));
  assign stall_inc_s = CNT_W'(sat_inc(SAT_W'(stall_r), SAT_W'(CNT_MAX)));
  // The watchdog compares the post-increment count, so it fires after exactly TO_VAL RUN cycles.
  assign timeout_hit_s = WDOG_EN && (cycle_inc_s == TO_VAL);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_filt
    agc_halt_filter #(
      .HALT_FILTER(HALT_FILTER)
    ) u_filt (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (start_ok_s),
      .enable     (run_act_s),
      .halt_in    (halt[i]),
      .halted_out (halted_mask[i]),
      .halted_next(halted_next_s[i])
    );
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RS_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort overrides everything, all-halted beats the watchdog.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = RS_IDLE;
    end else begin
      case (state_r)
        RS_IDLE, RS_DONE, RS_TIMEOUT: begin
          if (start) state_s = RS_HOLD;
          else       state_s = state_r;
        end
        RS_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) state_s = RS_RUN;
          else                         state_s = RS_HOLD;
        end
        RS_RUN: begin
          if (&halted_next_s)     state_s = RS_DONE;
          else if (timeout_hit_s) state_s = RS_TIMEOUT;
          else                    state_s = RS_RUN;
        end
        default: state_s = RS_IDLE;
      endcase
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    core_reset_n = 1'b0;
    running      = 1'b0;
    done         = 1'b0;
    timed_out    = 1'b0;
    case (state_r)
      RS_RUN: begin
        core_reset_n = 1'b1;
        running      = 1'b1;
      end
      RS_DONE: begin
        core_reset_n = 1'b1;
        done         = 1'b1;
      end
      RS_TIMEOUT: begin
        core_reset_n = 1'b1;
        timed_out    = 1'b1;
      end
      default: core_reset_n = 1'b0;
    endcase
  end

  // Hold timer and run accounting; values freeze outside RUN and survive abort.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_r <= '0;
      cycle_r    <= '0;
      stall_r    <= '0;
    end else if (start_ok_s) begin
      hold_cnt_r <= '0;
      cycle_r    <= '0;
      stall_r    <= '0;
    end else if (run_act_s) begin
      cycle_r <= cycle_inc_s;
      if (|stall) stall_r <= stall_inc_s;
    end else if (hold_act_s) begin
      hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
    end
  end

  assign cycle_count = cycle_r;
  assign stall_count = stall_r;

endmodule

// File: tb/tb_agc_run_ctrl.sv
// Self-checking bench for agc_run_ctrl: a 3-core instance with a 50-cycle
// watchdog and a 1-core 4-bit-counter instance for saturation.
module tb_agc_run_ctrl;
  localparam int NC = 3, RH = 4, HF = 2, TO = 50;
  localparam int RH_B = 1, HF_B = 3, CW_B = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          start_a, abort_a;
  logic [NC-1:0] halt_a, stall_a;
  logic          core_reset_n_a, running_a, done_a, timed_out_a;
  logic [NC-1:0] halted_mask_a;
  logic [31:0]   cycle_count_a, stall_count_a;

  logic          start_b, abort_b;
  logic [0:0]    halt_b, stall_b;
  logic          core_reset_n_b, running_b, done_b, timed_out_b;
  logic [0:0]    halted_mask_b;
  logic [CW_B-1:0] cycle_count_b, stall_count_b;

  agc_run_ctrl #(.NUM_CORES(NC), .RESET_HOLD(RH), .HALT_FILTER(HF),
                 .TIMEOUT_CYCLES(TO), .CNT_W(32)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .abort(abort_a),
    .halt(halt_a), .stall(stall_a), .core_reset_n(core_reset_n_a),
    .running(running_a), .done(done_a), .timed_out(timed_out_a),
    .halted_mask(halted_mask_a), .cycle_count(cycle_count_a),
    .stall_count(stall_count_a));

  agc_run_ctrl #(.NUM_CORES(1), .RESET_HOLD(RH_B), .HALT_FILTER(HF_B),
                 .TIMEOUT_CYCLES(0), .CNT_W(CW_B)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .abort(abort_b),
    .halt(halt_b), .stall(stall_b), .core_reset_n(core_reset_n_b),
    .running(running_b), .done(done_b), .timed_out(timed_out_b),
    .halted_mask(halted_mask_b), .cycle_count(cycle_count_b),
    .stall_count(stall_count_b));

  int n_tests = 0;
  int n_fail  = 0;
  logic [NC-1:0] h_stim [64];
  logic [NC-1:0] s_stim [64];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full run on dut_a from the stimulus tables, checked against a model
  // that scans the tables for each core's first HF-long run of halt ones.
  task automatic run_a(input string tag);
    int set_idx [NC];
    int run_len, done_at, end_n, exp_stall, got_n;
    bit exp_done;
    logic [NC-1:0] exp_mask;
    done_at = 0;
    for (int c = 0; c < NC; c++) begin
      set_idx[c] = 1000;
      run_len = 0;
      for (int i = 0; i < 64; i++) begin
        run_len = h_stim[i][c] ? run_len + 1 : 0;
        if (run_len == HF && set_idx[c] == 1000) set_idx[c] = i;
      end
      if (set_idx[c] > done_at) done_at = set_idx[c];
    end
    exp_done  = (done_at + 1 <= TO);
    end_n     = exp_done ? done_at + 1 : TO;
    exp_stall = 0;
    for (int i = 0; i < end_n; i++) if (|s_stim[i]) exp_stall++;

    start_a = 1'b1; halt_a = '1; stall_a = '1;
    step();
    for (int h = 0; h < RH; h++) begin
      start_a = 1'($urandom_range(1, 0));
      n_tests++;
      if (core_reset_n_a !== 1'b0 || running_a !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold%0d: core_reset_n=%b running=%b, want 0 0", tag, h, core_reset_n_a, running_a);
      end
      step();
    end
    n_tests++;
    if (running_a !== 1'b1 || core_reset_n_a !== 1'b1 || cycle_count_a !== 32'd0) begin
      n_fail++;
      $display("FAIL %s run_entry: running=%b core_reset_n=%b cycle=%0d, want 1 1 0", tag, running_a, core_reset_n_a, cycle_count_a);
    end
    got_n = 0;
    for (int i = 0; i < 64; i++) begin
      halt_a = h_stim[i]; stall_a = s_stim[i];
      start_a = 1'($urandom_range(1, 0));
      step();
      start_a = 1'b0;
      got_n = i + 1;
      exp_mask = '0;
      for (int c = 0; c < NC; c++) exp_mask[c] = (set_idx[c] <= i);
      n_tests++;
      if (halted_mask_a !== exp_mask || cycle_count_a !== 32'(i + 1)) begin
        n_fail++;
        $display("FAIL %s cyc%0d: mask=%b cycle=%0d, want mask=%b cycle=%0d", tag, i, halted_mask_a, cycle_count_a, exp_mask, i + 1);
      end
      if (!running_a) break;
    end
    n_tests++;
    if (got_n !== end_n || done_a !== exp_done || timed_out_a !== !exp_done ||
        stall_count_a !== 32'(exp_stall) || core_reset_n_a !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end: len=%0d done=%b to=%b stall=%0d crn=%b, want len=%0d done=%b to=%b stall=%0d crn=1",
               tag, got_n, done_a, timed_out_a, stall_count_a, core_reset_n_a, end_n, exp_done, !exp_done, exp_stall);
    end
    halt_a = NC'($urandom); stall_a = '1;
    step();
    n_tests++;
    if (cycle_count_a !== 32'(end_n) || stall_count_a !== 32'(exp_stall) || halted_mask_a !== exp_mask ||
        done_a !== exp_done) begin
      n_fail++;
      $display("FAIL %s frozen: cycle=%0d stall=%0d mask=%b done=%b, want %0d %0d %b %b",
               tag, cycle_count_a, stall_count_a, halted_mask_a, done_a, end_n, exp_stall, exp_mask, exp_done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; halt_a = '0; stall_a = '0;
    start_b = 1'b0; abort_b = 1'b0; halt_b = '0; stall_b = '0;
    #12;
    n_tests++;
    if ({core_reset_n_a, running_a, done_a, timed_out_a} !== 4'b0000 || halted_mask_a !== 3'b000 ||
        cycle_count_a !== 32'd0 || stall_count_a !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_a: flags=%b mask=%b cycle=%0d stall=%0d, want all 0",
               {core_reset_n_a, running_a, done_a, timed_out_a}, halted_mask_a, cycle_count_a, stall_count_a);
    end
    n_tests++;
    if ({core_reset_n_b, running_b, done_b, timed_out_b} !== 4'b0000 || halted_mask_b !== 1'b0 ||
        cycle_count_b !== 4'd0 || stall_count_b !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_b: flags=%b mask=%b cycle=%0d stall=%0d, want all 0",
               {core_reset_n_b, running_b, done_b, timed_out_b}, halted_mask_b, cycle_count_b, stall_count_b);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_filter_pattern();
    for (int i = 0; i < 64; i++) begin
      h_stim[i] = 3'b111;
      s_stim[i] = (i == 1) ? 3'b010 : 3'b000;
    end
    h_stim[1] = 3'b110;
    run_a("filter_1011");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++) begin
        for (int c = 0; c < NC; c++) h_stim[i][c] = ($urandom_range(9, 0) < 32'(5 + r));
        s_stim[i] = NC'($urandom);
      end
      run_a($sformatf("random%0d", r));
    end
  endtask

  task automatic test_timeout();
    int onset0, onset2;
    onset0 = $urandom_range(40, 2);
    onset2 = $urandom_range(40, 2);
    for (int i = 0; i < 64; i++) begin
      h_stim[i][0] = (i >= onset0) ? 1'b1 : 1'($urandom);
      h_stim[i][1] = 1'(i % 2);
      h_stim[i][2] = (i >= onset2) ? 1'b1 : 1'($urandom);
      s_stim[i] = NC'($urandom);
    end
    run_a("timeout");
    n_tests++;
    if (timed_out_a !== 1'b1 || cycle_count_a !== 32'd50 || halted_mask_a !== 3'b101) begin
      n_fail++;
      $display("FAIL timeout_fixed: to=%b cycle=%0d mask=%b, want 1 50 101", timed_out_a, cycle_count_a, halted_mask_a);
    end
  endtask

  task automatic test_done_wins();
    for (int i = 0; i < 64; i++) begin
      h_stim[i] = {(i >= 48), 2'b11};
      s_stim[i] = '0;
    end
    run_a("done_on_watchdog");
    n_tests++;
    if (done_a !== 1'b1 || timed_out_a !== 1'b0 || cycle_count_a !== 32'd50) begin
      n_fail++;
      $display("FAIL done_wins: done=%b to=%b cycle=%0d, want 1 0 50", done_a, timed_out_a, cycle_count_a);
    end
    for (int i = 0; i < 64; i++) h_stim[i] = {(i >= 49), 2'b11};
    run_a("one_late");
  endtask

  task automatic test_saturation();
    bit st [20];
    int k, got_n, exp_c;
    k = 0;
    foreach (st[j]) st[j] = 1'b0;
    while (k < 7) begin
      int p;
      p = $urandom_range(19, 0);
      if (!st[p]) begin st[p] = 1'b1; k++; end
    end
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    n_tests++;
    if (core_reset_n_b !== 1'b0 || running_b !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_hold: core_reset_n=%b running=%b, want 0 0", core_reset_n_b, running_b);
    end
    step();
    n_tests++;
    if (core_reset_n_b !== 1'b1 || running_b !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_run_entry: core_reset_n=%b running=%b, want 1 1", core_reset_n_b, running_b);
    end
    got_n = 0;
    for (int i = 0; i < 40; i++) begin
      halt_b  = ((i >= 20 && i <= 22) || i == 5 || i == 6) ? 1'b1 : 1'b0;
      stall_b = (i < 20) ? st[i] : 1'b0;
      step();
      got_n = i + 1;
      exp_c = (i + 1 > 15) ? 15 : i + 1;
      n_tests++;
      if (cycle_count_b !== CW_B'(exp_c) || halted_mask_b !== 1'(i >= 22)) begin
        n_fail++;
        $display("FAIL sat cyc%0d: cycle=%0d mask=%b, want %0d %b", i, cycle_count_b, halted_mask_b, exp_c, (i >= 22));
      end
      if (!running_b) break;
    end
    n_tests++;
    if (got_n !== 23 || done_b !== 1'b1 || timed_out_b !== 1'b0 || stall_count_b !== 4'd7) begin
      n_fail++;
      $display("FAIL sat_end: len=%0d done=%b to=%b stall=%0d, want 23 1 0 7", got_n, done_b, timed_out_b, stall_count_b);
    end
    halt_b = '0; stall_b = '0;
  endtask

  task automatic test_abort();
    int exp_stall;
    exp_stall = 0;
    halt_a = '0; stall_a = '0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int h = 0; h < RH; h++) step();
    for (int i = 0; i < 10; i++) begin
      stall_a = NC'($urandom);
      if (|stall_a) exp_stall++;
      step();
    end
    abort_a = 1'b1; start_a = 1'b1; stall_a = '1;
    step();
    abort_a = 1'b0; start_a = 1'b0;
    n_tests++;
    if (running_a !== 1'b0 || core_reset_n_a !== 1'b0 || done_a !== 1'b0 ||
        cycle_count_a !== 32'd10 || stall_count_a !== 32'(exp_stall)) begin
      n_fail++;
      $display("FAIL abort: running=%b crn=%b done=%b cycle=%0d stall=%0d, want 0 0 0 10 %0d",
               running_a, core_reset_n_a, done_a, cycle_count_a, stall_count_a, exp_stall);
    end
    for (int h = 0; h <= RH; h++) step();
    n_tests++;
    if (running_a !== 1'b0 || core_reset_n_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: running=%b crn=%b, want 0 0", running_a, core_reset_n_a);
    end
  endtask

  task automatic test_async_reset();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({core_reset_n_a, running_a, done_a, timed_out_a} !== 4'b0000 || halted_mask_a !== 3'b000 ||
        cycle_count_a !== 32'd0 || stall_count_a !== 32'd0) begin
      n_fail++;
      $display("FAIL async_hold: flags=%b mask=%b cycle=%0d, want 0", {core_reset_n_a, running_a, done_a, timed_out_a},
               halted_mask_a, cycle_count_a);
    end
    step();
    reset_n = 1'b1;
    for (int h = 0; h < RH + 2; h++) step();
    n_tests++;
    if (running_a !== 1'b0 || core_reset_n_a !== 1'b0) begin
      n_fail++;
      $display("FAIL async_idle: running=%b crn=%b, want 0 0", running_a, core_reset_n_a);
    end
    for (int i = 0; i < 64; i++) begin
      h_stim[i] = NC'($urandom) | ((i > 8) ? 3'b111 : 3'b000);
      s_stim[i] = NC'($urandom);
    end
    run_a("pre_reset");
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({core_reset_n_a, running_a, done_a, timed_out_a} !== 4'b0000 || halted_mask_a !== 3'b000 ||
        cycle_count_a !== 32'd0 || stall_count_a !== 32'd0) begin
      n_fail++;
      $display("FAIL async_done: flags=%b mask=%b cycle=%0d stall=%0d, want 0",
               {core_reset_n_a, running_a, done_a, timed_out_a}, halted_mask_a, cycle_count_a, stall_count_a);
    end
    step();
    reset_n = 1'b1;
    step();
    run_a("after_reset");
  endtask

  initial begin
    test_reset();
    test_filter_pattern();
    test_random();
    test_timeout();
    test_done_wins();
    test_saturation();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
